// File: rtl/burst_line_adaptor_pkg.sv
// Shared types and default geometry for the cache-line to memory-burst adaptor.
// Per-instance geometry is derived from the top-level parameters.
package burst_line_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_LINE_W  = 256;
    localparam int DEF_BURST_W = 64;
    localparam int DEF_ADDR_W  = 32;

    localparam int BEATS      = DEF_LINE_W / DEF_BURST_W;
    localparam int IDX_W      = $clog2(BEATS);
    localparam int LINE_OFS_W = $clog2(DEF_LINE_W / 8);
    localparam int BEAT_OFS_W = $clog2(DEF_BURST_W / 8);

endpackage

// File: rtl/burst_line_adaptor_beat_sequencer.sv
// Beat counter and slot index generator for one line transfer.
// With WRAP_BURST_EN defined the index starts at the critical slot and wraps.
module beat_sequencer #(
    parameter int BEATS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W-1:0] offset,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] start;

`ifdef WRAP_BURST_EN
    assign start = offset;
`else
    logic unused_offset;
    assign start         = '0;
    assign unused_offset = ^offset;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    // BEATS is a power of two, so the natural IDX_W-bit overflow is the wrap.
    assign idx  = start + cnt;
    assign last = (cnt == IDX_W'(BEATS - 1));

endmodule

// File: rtl/burst_line_adaptor.sv
// Adapts full-line cache requests to BURST_W-wide memory beats.
// Define WRAP_BURST_EN for critical-beat-first wrap ordering.
module burst_line_adaptor
    import burst_line_adaptor_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic [1:0]         fsm_state
);

    localparam int L_BEATS      = LINE_W / BURST_W;
    localparam int L_IDX_W      = $clog2(L_BEATS);
    localparam int L_LINE_OFS_W = $clog2(LINE_W / 8);
    localparam int L_BEAT_OFS_W = $clog2(BURST_W / 8);

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   line_q;
    logic [L_IDX_W-1:0]  idx;
    logic                last;
    logic                accept;
    logic                beat;
    logic                unused_addr_bits;

    assign accept = (state == IDLE) && (read_i || write_i);
    assign beat   = ((state == READ) || (state == WRITE)) && resp_i;

    beat_sequencer #(
        .BEATS (L_BEATS),
        .IDX_W (L_IDX_W)
    ) u_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .advance (beat),
        .offset  (addr_q[L_LINE_OFS_W-1:L_BEAT_OFS_W]),
        .idx     (idx),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // All memory-side strobes are pure state decodes, so they drop with reset_n.
    always_comb begin
        state_n = state;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state)
            IDLE: begin
                if (read_i) begin
                    state_n = READ;
                end else if (write_i) begin
                    state_n = WRITE;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && last) begin
                    state_n = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                burst_o = line_q[int'(idx) * BURST_W +: BURST_W];
                if (resp_i && last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            line_q <= '0;
            line_o <= '0;
        end else begin
            if (accept) begin
                addr_q <= address_i;
                if (!read_i) begin
                    line_q <= line_i;
                end
            end
            if ((state == READ) && resp_i) begin
                line_o[int'(idx) * BURST_W +: BURST_W] <= burst_i;
            end
        end
    end

`ifdef WRAP_BURST_EN
    assign address_o = {addr_q[ADDR_W-1:L_BEAT_OFS_W], {L_BEAT_OFS_W{1'b0}}};
`else
    assign address_o = {addr_q[ADDR_W-1:L_LINE_OFS_W], {L_LINE_OFS_W{1'b0}}};
`endif

    // Byte offset within a beat never reaches memory in either ordering mode.
    assign unused_addr_bits = ^addr_q[L_BEAT_OFS_W-1:0];
    assign fsm_state        = state;

endmodule

// File: doc/burst_line_adaptor.md
# burst_line_adaptor

Parametrised adaptor between the last-level cache (one full line per request) and burst memory (one BURST_W beat per resp_i cycle). It is the generalised successor of the fixed 256/64 adaptor:
- Line and burst widths are parameters.
- Request address and write line are registered at acceptance.
- Stray resp_i is ignored outside a transfer.
- Critical-beat-first wrap ordering is available at compile time.

It sits between the cache datapath and the memory port of the top level.

## Interface
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width in bits; LINE_W/BURST_W = BEATS, power of two, ≥2
- ADDR_W, 32, address width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- line_i  in  LINE_W  write line from cache
- line_o  out  LINE_W  assembled read line
- address_i  in  ADDR_W  cache request byte address
- read_i  in  1  cache read request
- write_i  in  1  cache write request
- resp_o  out  1  one-cycle completion pulse
- burst_i  in  BURST_W  memory read beat
- burst_o  out  BURST_W  memory write beat
- address_o  out  ADDR_W  memory address
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat accepted/valid

## Operation
- States: IDLE, READ, WRITE, DONE. Beat counter cnt is log2(BEATS) bits.
- IDLE: a request is accepted when read_i or write_i is high.
  - read_i wins if both are high.
  - On acceptance, address_i and (for writes) line_i are captured into addr_q and line_q; cnt is cleared.
  - Next state is READ or WRITE.
- READ: read_o=1.
  - On each resp_i, burst_i is written to line slot idx, where idx = (start+cnt) mod BEATS; then cnt increments.
  - The resp_i that arrives with cnt=BEATS-1 moves the FSM to DONE.
- WRITE: write_o=1 and burst_o = line_q slot idx.
  - Same counting and exit rule as READ.
- DONE: resp_o=1 for exactly one cycle, then IDLE. read_i and write_i are ignored here.
- resp_i in IDLE or DONE: ignored. No line_o change, no counter change.
- line_o is the registered line buffer. It holds the last completed read until the next read overwrites it beat by beat.
- address_o is driven from addr_q (see Configuration). Outside READ and WRITE it holds its last value.
- Reset, including mid-transfer:
  - State goes to IDLE; cnt, addr_q, line_q and line_o go to 0.
  - read_o, write_o, resp_o and burst_o are 0.
  - These outputs decode from state, so they fall asynchronously with reset_n.
  - No resp_o is produced for the aborted transfer.

## Timing
- Request sampled at edge 0; read_o/write_o high from cycle 1. They are Moore outputs with no combinational path from read_i/write_i.
- A transfer takes BEATS cycles with resp_i high; resp_i may stall indefinitely.
- resp_o asserts in the cycle after the final beat. Minimum latency from request to resp_o is BEATS+1 cycles.
- line_o is valid in the resp_o cycle and afterwards.
- The earliest next request is accepted in the cycle after resp_o (IDLE).
- burst_o changes only on the edge following a resp_i.

## Configuration
- WRAP_BURST_EN undefined:
  - start=0.
  - address_o = addr_q with low log2(LINE_W/8) bits zeroed (line aligned).
  - Beats are transferred in ascending slot order.
- WRAP_BURST_EN defined:
  - start = addr_q[log2(LINE_W/8)-1 : log2(BURST_W/8)].
  - address_o = addr_q with low log2(BURST_W/8) bits zeroed.
  - Beats start at the critical slot and wrap modulo BEATS; memory is required to return them in the same order.

## Structure
- Package burst_line_adaptor_pkg holds:
  - the state enum;
  - localparams BEATS, IDX_W = $clog2(BEATS), LINE_OFS_W = $clog2(LINE_W/8), BEAT_OFS_W = $clog2(BURST_W/8).
- One sub-module, beat_sequencer, owns cnt, the start offset and the wrap index computation. It outputs idx and a last flag.

## Test plan
- Read, default params, no macro: address_i=0x1234_5678 → address_o=0x1234_5660; beats 0xA..0xD on 4 consecutive resp_i → line_o={D,C,B,A}, resp_o at cycle 5.
- Write, line_i=0x…0004_…0003_…0002_…0001 (beats 1,2,3,4), resp_i stalled 2 cycles before beat 3 → burst_o sequence 1,2,3,4, each held until its resp_i; resp_o a single cycle.
- read_i and write_i both high in IDLE → READ taken, write_o never asserts. resp_i pulses in IDLE → line_o unchanged.
- reset_n low after 2 beats of a read → read_o drops immediately, state IDLE, no resp_o; a new read then completes normally.
- WRAP_BURST_EN defined, address_i=0x0000_0050 → address_o=0x0000_0050, beats land in slots 2,3,0,1.
- LINE_W=512, BURST_W=128 read → exactly 4 beats, resp_o after the 4th, line_o correctly assembled.
